// File: rtl/microc_uc_seq_if.sv
// Control bundle between the microc sequencer and its datapath.
// The sequencer side (master) consumes the opcode/flag and operator
// controls and drives every datapath control plus the status outputs.
interface microc_uc_seq_if #(
  parameter int CNT_W = 16
);
  // datapath / operator -> sequencer
  logic [5:0]       Opcode;
  logic             z;
  logic             run;
  logic             step;
  // sequencer -> datapath
  logic             s_inc;
  logic             s_inm;
  logic             we3;
  logic             wez;
  logic [2:0]       Op;
  logic             pc_en;
  // sequencer status
  logic             halted;
  logic [5:0]       bad_op;
  logic [CNT_W-1:0] icount;

  modport master (
    input  Opcode, z, run, step,
    output s_inc, s_inm, we3, wez, Op, pc_en, halted, bad_op, icount
  );

  modport slave (
    output Opcode, z, run, step,
    input  s_inc, s_inm, we3, wez, Op, pc_en, halted, bad_op, icount
  );
endinterface

// File: rtl/microc_uc_seq.sv
// Sequencing control unit for the single-cycle microc datapath.
// Decodes Opcode/z into datapath controls, gates execution through a
// run/pause/single-step/halt FSM, counts executed instructions and traps
// illegal opcodes. Only the FSM state, the step edge detector, the
// instruction counter and the trap opcode are registered; every datapath
// control is combinational so it is valid in the cycle Opcode appears.
module microc_uc_seq #(
  parameter int CNT_W    = 16,
  parameter bit AUTO_RUN = 1'b0
) (
  input  logic          clk,
  input  logic          reset,   // asynchronous, active low
  microc_uc_seq_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    STEP  = 3'd2,
    PAUSE = 3'd3,
    HALT  = 3'd4
  } state_t;

  state_t           state_reg, state_next;
  logic             step_prev_reg;
  logic [CNT_W-1:0] icount_reg;
  logic [5:0]       bad_op_reg;

  // raw decode, before execute gating
  logic       dec_legal;
  logic       dec_s_inc;
  logic       dec_s_inm;
  logic       dec_we3;
  logic       dec_wez;
  logic [2:0] dec_op;

  // gated outputs
  logic       active;
  logic       step_rise;
  logic       s_inc;
  logic       s_inm;
  logic       we3;
  logic       wez;
  logic [2:0] op;
  logic       pc_en;

  assign active    = (state_reg == RUN) || (state_reg == STEP);
  assign step_rise = bus.step & ~step_prev_reg;

  // Instruction decode; anything not matched stays illegal with no writes.
  always_comb begin
    dec_legal = 1'b0;
    dec_s_inc = 1'b1;
    dec_s_inm = 1'b0;
    dec_we3   = 1'b0;
    dec_wez   = 1'b0;
    dec_op    = 3'b000;
    casez (bus.Opcode)
      6'b1?????: begin  // ALU operation, result and zero flag written
        dec_legal = 1'b1;
        dec_we3   = 1'b1;
        dec_wez   = 1'b1;
        dec_op    = bus.Opcode[4:2];
      end
      6'b0001??: begin  // li: load immediate
        dec_legal = 1'b1;
        dec_s_inm = 1'b1;
        dec_we3   = 1'b1;
      end
      6'b010000: begin  // j
        dec_legal = 1'b1;
        dec_s_inc = 1'b0;
      end
      6'b010001: begin  // jz: jump when zero flag set
        dec_legal = 1'b1;
        dec_s_inc = ~bus.z;
      end
      6'b010010: begin  // jnz: jump when zero flag clear
        dec_legal = 1'b1;
        dec_s_inc = bus.z;
      end
      6'b000000: begin  // nop
        dec_legal = 1'b1;
      end
      default: begin
        dec_legal = 1'b0;
      end
    endcase
  end

  // Execute gating: reset forces everything low, inactive states freeze
  // the PC, and an illegal opcode never writes or advances.
  always_comb begin
    s_inc = 1'b1;
    s_inm = 1'b0;
    we3   = 1'b0;
    wez   = 1'b0;
    op    = 3'b000;
    pc_en = 1'b0;
    if (!reset) begin
      s_inc = 1'b0;
    end else if (active) begin
      s_inc = dec_s_inc;
      s_inm = dec_s_inm;
      we3   = dec_we3 & dec_legal;
      wez   = dec_wez & dec_legal;
      op    = dec_op;
      pc_en = dec_legal;
    end
  end

  // Next-state logic for the run/pause/step/halt sequencer.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (AUTO_RUN || bus.run) state_next = RUN;
        else if (step_rise)      state_next = STEP;
      end
      PAUSE: begin
        if (bus.run)        state_next = RUN;
        else if (step_rise) state_next = STEP;
      end
      RUN: begin
        if (!dec_legal)    state_next = HALT;
        else if (!bus.run) state_next = PAUSE;
      end
      STEP: begin
        state_next = dec_legal ? PAUSE : HALT;
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register and step edge-detector history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      step_prev_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      step_prev_reg <= bus.step;
    end
  end

  // Executed-instruction counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      icount_reg <= '0;
    end else if (pc_en) begin
      icount_reg <= icount_reg + 1'b1;
    end
  end

  // Capture the offending opcode on the edge that enters HALT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bad_op_reg <= 6'd0;
    end else if (state_next == HALT && state_reg != HALT) begin
      bad_op_reg <= bus.Opcode;
    end
  end

  assign bus.s_inc  = s_inc;
  assign bus.s_inm  = s_inm;
  assign bus.we3    = we3;
  assign bus.wez    = wez;
  assign bus.Op     = op;
  assign bus.pc_en  = pc_en;
  assign bus.halted = (state_reg == HALT);
  assign bus.bad_op = bad_op_reg;
  assign bus.icount = icount_reg;

endmodule

// File: tb/tb_microc_uc_seq.sv
// Bench for microc_uc_seq: a small behavioural microc datapath (PC,
// register file, zero flag, program ROM) is driven by the sequencer.
// Expected control words are queued when a program is launched and
// popped one per executed cycle.
module tb_microc_uc_seq;
  localparam int CNT_W = 4;

  localparam logic [5:0] OP_NOP = 6'h00;
  localparam logic [5:0] OP_LI  = 6'h04;
  localparam logic [5:0] OP_J   = 6'h10;
  localparam logic [5:0] OP_JNZ = 6'h12;
  localparam logic [5:0] OP_ADD = 6'h28;
  localparam logic [5:0] OP_SUB = 6'h2C;
  localparam logic [5:0] OP_ILL = 6'h0C;

  // control word {s_inc, s_inm, we3, wez, Op, pc_en}
  localparam logic [7:0] CW_LI    = {1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1};
  localparam logic [7:0] CW_ADD   = {1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 1'b1};
  localparam logic [7:0] CW_SUB   = {1'b1, 1'b0, 1'b1, 1'b1, 3'b011, 1'b1};
  localparam logic [7:0] CW_JTAKE = {1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1};
  localparam logic [7:0] CW_JFALL = {1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1};
  localparam logic [7:0] CW_NOP   = {1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1};

  logic clk = 1'b0;
  logic reset;
  logic dp_rst;

  microc_uc_seq_if #(.CNT_W(CNT_W)) bus ();

  microc_uc_seq #(.CNT_W(CNT_W), .AUTO_RUN(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // program ROM and datapath state
  logic [5:0] p_op   [16];
  logic [3:0] p_a    [16];
  logic [3:0] p_b    [16];
  logic [3:0] p_d    [16];
  logic [7:0] p_imm  [16];
  logic [3:0] p_addr [16];
  logic [3:0] pc;
  logic [7:0] rf [16];
  logic       zf;
  logic [7:0] alu_y;

  assign bus.Opcode = p_op[pc];
  assign bus.z      = zf;

  always_comb begin
    alu_y = 8'd0;
    case (bus.Op)
      3'b010:  alu_y = rf[p_a[pc]] + rf[p_b[pc]];
      3'b011:  alu_y = rf[p_a[pc]] - rf[p_b[pc]];
      default: alu_y = 8'd0;
    endcase
  end

  always @(posedge clk) begin
    if (dp_rst) begin
      pc <= 4'd0;
      zf <= 1'b0;
      for (int i = 0; i < 16; i++) rf[i] <= 8'd0;
    end else begin
      if (bus.pc_en) pc <= bus.s_inc ? pc + 4'd1 : p_addr[pc];
      if (bus.we3)   rf[p_d[pc]] <= bus.s_inm ? p_imm[pc] : alu_y;
      if (bus.wez)   zf <= (alu_y == 8'd0);
    end
  end

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  function automatic logic [7:0] ctl_word();
    return {bus.s_inc, bus.s_inm, bus.we3, bus.wez, bus.Op, bus.pc_en};
  endfunction

  task automatic sb_pop_check(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check_val({tag, "_underflow"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_val(tag, 32'(ctl_word()), 32'(e));
    end
  endtask

  task automatic set_instr(input int idx, input logic [5:0] op, input logic [3:0] a,
                           input logic [3:0] b, input logic [3:0] d,
                           input logic [7:0] imm, input logic [3:0] addr);
    p_op[idx] = op; p_a[idx] = a; p_b[idx] = b; p_d[idx] = d;
    p_imm[idx] = imm; p_addr[idx] = addr;
  endtask

  task automatic load_nops();
    for (int i = 0; i < 16; i++) set_instr(i, OP_NOP, 4'd0, 4'd0, 4'd0, 8'd0, 4'd0);
  endtask

  task automatic load_loop_prog();
    load_nops();
    set_instr(0, OP_LI,  4'd0, 4'd0, 4'd2, 8'd0, 4'd0);
    set_instr(1, OP_LI,  4'd0, 4'd0, 4'd1, 8'd2, 4'd0);
    set_instr(2, OP_LI,  4'd0, 4'd0, 4'd3, 8'd4, 4'd0);
    set_instr(3, OP_LI,  4'd0, 4'd0, 4'd4, 8'd1, 4'd0);
    set_instr(4, OP_ADD, 4'd2, 4'd3, 4'd2, 8'd0, 4'd0);
    set_instr(5, OP_SUB, 4'd1, 4'd4, 4'd1, 8'd0, 4'd0);
    set_instr(6, OP_JNZ, 4'd0, 4'd0, 4'd0, 8'd0, 4'd4);
    set_instr(7, OP_J,   4'd0, 4'd0, 4'd0, 8'd0, 4'd7);
  endtask

  // Reset the DUT and the datapath together, leaving run/step low.
  task automatic full_reset();
    @(negedge clk);
    bus.run = 1'b0; bus.step = 1'b0;
    reset = 1'b0; dp_rst = 1'b1;
    @(negedge clk);
    reset = 1'b1; dp_rst = 1'b0;
  endtask

  initial begin
    int pc_en_sum;
    int found;

    reset = 1'b0; dp_rst = 1'b1;
    bus.run = 1'b0; bus.step = 1'b0;
    load_loop_prog();

    // reset state
    repeat (2) @(negedge clk);
    check_val("rst_ctl", 32'(ctl_word()), 32'd0);
    check_val("rst_halted", 32'(bus.halted), 32'd0);
    check_val("rst_icount", 32'(bus.icount), 32'd0);
    check_val("rst_bad_op", 32'(bus.bad_op), 32'd0);

    // release with run low: PC stays frozen
    reset = 1'b1; dp_rst = 1'b0;
    pc_en_sum = 0;
    repeat (10) begin
      @(negedge clk);
      pc_en_sum += int'(bus.pc_en);
    end
    check_val("idle_pc_en_sum", 32'(pc_en_sum), 32'd0);
    check_val("idle_pc", 32'(pc), 32'd0);
    check_val("idle_s_inc", 32'(bus.s_inc), 32'd1);

    // program run
    exp_q.push_back(CW_LI);  exp_q.push_back(CW_LI);
    exp_q.push_back(CW_LI);  exp_q.push_back(CW_LI);
    exp_q.push_back(CW_ADD); exp_q.push_back(CW_SUB); exp_q.push_back(CW_JTAKE);
    exp_q.push_back(CW_ADD); exp_q.push_back(CW_SUB); exp_q.push_back(CW_JFALL);
    exp_q.push_back(CW_JTAKE);
    bus.run = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      sb_pop_check($sformatf("prog_ctl%0d", i));
      @(negedge clk);
    end
    check_val("prog_icount", 32'(bus.icount), 32'd11);
    check_val("prog_r2", 32'(rf[2]), 32'd8);

    // run drop while on j: j executes once more, then paused
    bus.run = 1'b0;
    @(negedge clk);
    check_val("pause_pc_en", 32'(bus.pc_en), 32'd0);
    check_val("pause_icount", 32'(bus.icount), 32'd12);

    // single step held for 5 cycles
    bus.step = 1'b1;
    pc_en_sum = 0;
    repeat (5) begin
      @(negedge clk);
      pc_en_sum += int'(bus.pc_en);
    end
    bus.step = 1'b0;
    check_val("step1_pc_en_sum", 32'(pc_en_sum), 32'd1);
    check_val("step1_icount", 32'(bus.icount), 32'd13);
    @(negedge clk);
    bus.step = 1'b1;
    repeat (2) @(negedge clk);
    bus.step = 1'b0;
    @(negedge clk);
    check_val("step2_icount", 32'(bus.icount), 32'd14);
    check_val("step2_pc_en", 32'(bus.pc_en), 32'd0);

    // drop run during sub
    full_reset();
    bus.run = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (bus.Opcode == OP_SUB && bus.pc_en) found = 1;
    end
    check_val("sub_found", 32'(found), 32'd1);
    check_val("sub_we3", 32'(bus.we3), 32'd1);
    bus.run = 1'b0;
    @(negedge clk);
    check_val("sub_pause_pc_en", 32'(bus.pc_en), 32'd0);
    check_val("sub_r1", 32'(rf[1]), 32'd1);
    bus.run = 1'b1; bus.step = 1'b1;
    @(negedge clk);
    check_val("run_step_pc_en0", 32'(bus.pc_en), 32'd1);
    @(negedge clk);
    check_val("run_step_pc_en1", 32'(bus.pc_en), 32'd1);
    bus.run = 1'b0; bus.step = 1'b0;
    @(negedge clk);
    check_val("run_step_stop", 32'(bus.pc_en), 32'd0);

    // illegal opcode trap
    load_nops();
    set_instr(0, OP_LI,  4'd0, 4'd0, 4'd5, 8'd9, 4'd0);
    set_instr(1, OP_ILL, 4'd0, 4'd0, 4'd5, 8'd3, 4'd0);
    full_reset();
    bus.run = 1'b1;
    @(negedge clk);
    check_val("ill_li_pc_en", 32'(bus.pc_en), 32'd1);
    @(negedge clk);
    check_val("ill_ctl", 32'({bus.pc_en, bus.we3, bus.wez}), 32'd0);
    check_val("ill_halted_pre", 32'(bus.halted), 32'd0);
    @(negedge clk);
    check_val("ill_halted", 32'(bus.halted), 32'd1);
    check_val("ill_bad_op", 32'(bus.bad_op), 32'(OP_ILL));
    bus.run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); bus.step = 1'b1;
      @(negedge clk); bus.step = 1'b0;
    end
    bus.run = 1'b1;
    repeat (2) @(negedge clk);
    check_val("ill_sticky", 32'({bus.halted, bus.pc_en}), 32'b10);
    check_val("ill_icount", 32'(bus.icount), 32'd1);
    check_val("ill_r5", 32'(rf[5]), 32'd9);
    full_reset();
    check_val("ill_cleared", 32'(bus.halted), 32'd0);

    // counter wrap with 17 nops, then reset mid-run
    load_nops();
    full_reset();
    for (int i = 0; i < 17; i++) exp_q.push_back(CW_NOP);
    bus.run = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      sb_pop_check($sformatf("nop_ctl%0d", i));
      @(negedge clk);
    end
    check_val("wrap_icount", 32'(bus.icount), 32'd1);
    check_val("sb_drained", 32'(exp_q.size()), 32'd0);
    reset = 1'b0;
    #1;
    check_val("midrun_rst_ctl", 32'(ctl_word()), 32'd0);
    check_val("midrun_rst_icount", 32'(bus.icount), 32'd0);
    @(negedge clk);
    bus.run = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_val("post_rst_idle", 32'(bus.pc_en), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time bound so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
